sys_spi_cmd: RTL and testbench

- Next-generation companion-MCU slave SPI command engine for the Tangcores system block.
- Decodes MCU commands into:
  - a bank of NUM_CFG 32-bit config registers,
  - overlay/text-display write strobes,
  - a ROM-load stream.
- ROM-load stream features: parametrised word width, FIFO buffering and valid/ready back-pressure.
- Adds a readable status byte on MISO, which the fixed single-register version lacks. Sits between the SPI pins and the core/textdisp.

---
 rtl/sys_pkg.sv | 22 ++
 rtl/sys_sync_fifo.sv | 45 ++++
 rtl/sys_spi_cmd.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sys_spi_cmd.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared definitions for the companion-MCU SPI command engine.
package sys_pkg;

  localparam logic [7:0] CMD_GETCONF = 8'd1;
  localparam logic [7:0] CMD_SETCFG  = 8'd2;
  localparam logic [7:0] CMD_OVERLAY = 8'd3;
  localparam logic [7:0] CMD_CURSOR  = 8'd4;
  localparam logic [7:0] CMD_STRING  = 8'd5;
  localparam logic [7:0] CMD_LOADING = 8'd6;
  localparam logic [7:0] CMD_ROMDATA = 8'd7;
  localparam logic [7:0] CMD_STATUS  = 8'd8;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_OVF     = 1;
  localparam int unsigned ST_LOADING = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ARG  = 1'b1
  } state_t;

endpackage

// File: rtl/sys_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module sys_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/sys_spi_cmd.sv
// Slave SPI command engine: config registers, text overlay strobes,
// buffered ROM-load stream and a readable status/config response on MISO.
module sys_spi_cmd
  import sys_pkg::*;
#(
  parameter int unsigned NUM_CFG    = 2,
  parameter logic [31:0] CFG_RESET  = 32'h0,
  parameter int unsigned ROM_W      = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CONF_LEN   = 23,
  parameter logic [8*CONF_LEN-1:0] CONF_STR = "Tangcores;-;V,v20240101"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sspi_cs,
  input  logic                   sspi_clk,
  input  logic                   sspi_mosi,
  output logic                   sspi_miso,
  output logic [32*NUM_CFG-1:0]  core_config,
  output logic                   overlay,
  output logic                   txt_cursor_we,
  output logic [15:0]            txt_cursor,
  output logic                   txt_char_we,
  output logic [7:0]             txt_char,
  output logic                   rom_loading,
  output logic [ROM_W-1:0]       rom_do,
  output logic                   rom_do_valid,
  input  logic                   rom_do_ready
);

  localparam int unsigned LANES = ROM_W / 8;

  logic [1:0] cs_s, sclk_s, mosi_s;
  logic       sclk_d, armed, active, rise, fall;
  logic [7:0] rx_q;
  logic [2:0] bit_cnt;
  logic       byte_done;
  state_t     state_q, state_d;
  logic       cmd_byte_c, arg_byte_c;

  logic [7:0]       cmd_q, argcnt_q, idx_q, x_q, tx_q;
  logic [23:0]      cfg_lo_q, remain_q;
  logic [15:0]      len_lo_q;
  logic [ROM_W-1:0] word_q, push_word_c;
  logic [1:0]       lane_q;
  logic             str_done_q, ovf_q;
  logic             rom_byte_c, push_c, pop, full, empty;
  logic [8:0]       conf_idx_c;
  logic [7:0]       conf_byte_c, status_c, resp_c;

  // armed blocks a frame that was already in progress when reset was applied
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s   <= 2'b00;
      sclk_s <= 2'b00;
      mosi_s <= 2'b00;
      sclk_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      cs_s   <= {cs_s[0], sspi_cs};
      sclk_s <= {sclk_s[0], sspi_clk};
      mosi_s <= {mosi_s[0], sspi_mosi};
      sclk_d <= sclk_s[1];
      if (cs_s[1]) armed <= 1'b1;
    end
  end

  assign active = !cs_s[1] && armed;
  assign rise   = sclk_s[1] && !sclk_d;
  assign fall   = !sclk_s[1] && sclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q      <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (!active) begin
        bit_cnt <= '0;
      end else if (rise) begin
        rx_q      <= {rx_q[6:0], mosi_s[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!active)                               state_d = S_IDLE;
    else if (byte_done && state_q == S_IDLE)   state_d = S_ARG;
  end

  always_comb begin
    cmd_byte_c = 1'b0;
    arg_byte_c = 1'b0;
    if (active && byte_done) begin
      cmd_byte_c = (state_q == S_IDLE);
      arg_byte_c = (state_q == S_ARG);
    end
  end

  // ROM byte packing: current byte merged into its lane of the pending word
  always_comb begin
    push_word_c = word_q;
    for (int l = 0; l < int'(LANES); l++) begin
      if (lane_q == 2'(l)) push_word_c[8*l +: 8] = rx_q;
    end
    rom_byte_c = arg_byte_c && (cmd_q == CMD_ROMDATA) && (argcnt_q >= 8'd3) && (remain_q != 24'd0);
    push_c     = rom_byte_c && ((lane_q == 2'(LANES-1)) || (remain_q == 24'd1));
  end

  // response for the byte slot that starts right after this byte
  always_comb begin
    conf_idx_c  = (state_q == S_IDLE) ? 9'd0 : ({1'b0, argcnt_q} + 9'd1);
    conf_byte_c = 8'h00;
    for (int i = 0; i < int'(CONF_LEN); i++) begin
      if (conf_idx_c == 9'(i)) conf_byte_c = CONF_STR[8*(CONF_LEN-1-i) +: 8];
    end
    status_c             = 8'h00;
    status_c[ST_FULL]    = full;
    status_c[ST_OVF]     = ovf_q;
    status_c[ST_LOADING] = rom_loading;
    resp_c = 8'h00;
    if (cmd_byte_c) begin
      if (rx_q == CMD_GETCONF)     resp_c = conf_byte_c;
      else if (rx_q == CMD_STATUS) resp_c = status_c;
    end else if (arg_byte_c && cmd_q == CMD_GETCONF) begin
      resp_c = conf_byte_c;
    end
  end

  assign sspi_miso = tx_q[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      core_config   <= {NUM_CFG{CFG_RESET}};
      overlay       <= 1'b0;
      txt_cursor_we <= 1'b0;
      txt_cursor    <= '0;
      txt_char_we   <= 1'b0;
      txt_char      <= '0;
      rom_loading   <= 1'b0;
      cmd_q         <= '0;
      argcnt_q      <= '0;
      idx_q         <= '0;
      x_q           <= '0;
      tx_q          <= '0;
      cfg_lo_q      <= '0;
      remain_q      <= '0;
      len_lo_q      <= '0;
      word_q        <= '0;
      lane_q        <= '0;
      str_done_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      txt_cursor_we <= 1'b0;
      txt_char_we   <= 1'b0;
      if (!active) begin
        tx_q   <= '0;
        word_q <= '0;
        lane_q <= '0;
      end else if (fall && bit_cnt != 3'd0) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (cmd_byte_c || arg_byte_c) tx_q <= resp_c;

      if (cmd_byte_c) begin
        cmd_q      <= rx_q;
        argcnt_q   <= '0;
        str_done_q <= 1'b0;
        remain_q   <= '0;
        word_q     <= '0;
        lane_q     <= '0;
      end

      if (arg_byte_c) begin
        if (argcnt_q != 8'hFF) argcnt_q <= argcnt_q + 8'd1;
        case (cmd_q)
          CMD_SETCFG: begin
            case (argcnt_q)
              8'd0: idx_q <= rx_q;
              8'd1: cfg_lo_q[7:0]   <= rx_q;
              8'd2: cfg_lo_q[15:8]  <= rx_q;
              8'd3: cfg_lo_q[23:16] <= rx_q;
              8'd4: begin
                for (int i = 0; i < int'(NUM_CFG); i++) begin
                  if (idx_q == 8'(i)) core_config[32*i +: 32] <= {rx_q, cfg_lo_q};
                end
              end
              default: ;
            endcase
          end
          CMD_OVERLAY: if (argcnt_q == 8'd0) overlay <= rx_q[0];
          CMD_CURSOR: begin
            if (argcnt_q == 8'd0) x_q <= rx_q;
            if (argcnt_q == 8'd1) begin
              txt_cursor    <= {rx_q, x_q};
              txt_cursor_we <= 1'b1;
            end
          end
          CMD_STRING: begin
            if (!str_done_q) begin
              if (rx_q == 8'h00) begin
                str_done_q <= 1'b1;
              end else begin
                txt_char    <= rx_q;
                txt_char_we <= 1'b1;
              end
            end
          end
          CMD_LOADING: if (argcnt_q == 8'd0) rom_loading <= rx_q[0];
          CMD_ROMDATA: begin
            case (argcnt_q)
              8'd0: len_lo_q[7:0]  <= rx_q;
              8'd1: len_lo_q[15:8] <= rx_q;
              8'd2: begin
                remain_q <= {rx_q, len_lo_q};
                word_q   <= '0;
                lane_q   <= '0;
              end
              default: begin
                if (rom_byte_c) begin
                  remain_q <= remain_q - 24'd1;
                  if (push_c) begin
                    word_q <= '0;
                    lane_q <= '0;
                  end else begin
                    word_q <= push_word_c;
                    lane_q <= lane_q + 2'd1;
                  end
                end
              end
            endcase
          end
          default: ;
        endcase
      end

      // overflow set takes priority over the status-read clear
      if (arg_byte_c && cmd_q == CMD_STATUS && argcnt_q == 8'd0) ovf_q <= 1'b0;
      if (push_c && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign rom_do_valid = !empty;
  assign pop          = rom_do_valid && rom_do_ready;

  sys_sync_fifo #(
    .W     (ROM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_word_c),
    .pop       (pop),
    .pop_data  (rom_do),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_sys_spi_cmd.sv
// Bench for sys_spi_cmd: bit-banged SPI master, queue scoreboards for strobes and ROM words.
module tb_sys_spi_cmd;

  localparam int unsigned NUM_CFG    = 2;
  localparam logic [31:0] CFG_RESET  = 32'hA5A5_5A5A;
  localparam int unsigned ROM_W      = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CONF_LEN   = 23;
  localparam int          HALF       = 100;

  logic                  clk;
  logic                  reset;
  logic                  sspi_cs, sspi_clk, sspi_mosi, sspi_miso;
  logic [32*NUM_CFG-1:0] core_config;
  logic                  overlay, txt_cursor_we, txt_char_we, rom_loading;
  logic [15:0]           txt_cursor;
  logic [7:0]            txt_char;
  logic [ROM_W-1:0]      rom_do;
  logic                  rom_do_valid, rom_do_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0]       exp_char_q [$];
  logic [15:0]      exp_cursor_q [$];
  logic [ROM_W-1:0] exp_rom_q [$];
  logic [7:0]       exp_miso_q [$];

  sys_spi_cmd #(
    .NUM_CFG    (NUM_CFG),
    .CFG_RESET  (CFG_RESET),
    .ROM_W      (ROM_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CONF_LEN   (CONF_LEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sspi_cs       (sspi_cs),
    .sspi_clk      (sspi_clk),
    .sspi_mosi     (sspi_mosi),
    .sspi_miso     (sspi_miso),
    .core_config   (core_config),
    .overlay       (overlay),
    .txt_cursor_we (txt_cursor_we),
    .txt_cursor    (txt_cursor),
    .txt_char_we   (txt_char_we),
    .txt_char      (txt_char),
    .rom_loading   (rom_loading),
    .rom_do        (rom_do),
    .rom_do_valid  (rom_do_valid),
    .rom_do_ready  (rom_do_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitors, sampled on the falling system clock edge
  logic [7:0]       m_char;
  logic [15:0]      m_cur;
  logic [ROM_W-1:0] m_rom;
  always @(negedge clk) begin
    if (!reset && txt_char_we) begin
      checks++;
      if (exp_char_q.size() == 0) begin
        errors++;
        $display("FAIL txt_char unexpected strobe got=%h", txt_char);
      end else begin
        m_char = exp_char_q.pop_front();
        if (txt_char !== m_char) begin
          errors++;
          $display("FAIL txt_char got=%h exp=%h", txt_char, m_char);
        end
      end
    end
    if (!reset && txt_cursor_we) begin
      checks++;
      if (exp_cursor_q.size() == 0) begin
        errors++;
        $display("FAIL txt_cursor unexpected strobe got=%h", txt_cursor);
      end else begin
        m_cur = exp_cursor_q.pop_front();
        if (txt_cursor !== m_cur) begin
          errors++;
          $display("FAIL txt_cursor got=%h exp=%h", txt_cursor, m_cur);
        end
      end
    end
    if (!reset && rom_do_valid && rom_do_ready) begin
      checks++;
      if (exp_rom_q.size() == 0) begin
        errors++;
        $display("FAIL rom_do unexpected word got=%h", rom_do);
      end else begin
        m_rom = exp_rom_q.pop_front();
        if (rom_do !== m_rom) begin
          errors++;
          $display("FAIL rom_do got=%h exp=%h", rom_do, m_rom);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
    for (int i = 7; i >= 0; i--) begin
      sspi_mosi = tx[i];
      #(HALF);
      rxb[i] = sspi_miso;
      sspi_clk = 1'b1;
      #(HALF);
      sspi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    sspi_cs = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    sspi_cs = 1'b1;
    #(2*HALF);
  endtask

  // sends the low n bytes of data, most significant of those first
  task automatic frame(input logic [127:0] data, input int n);
    logic [7:0] b, r;
    cs_low();
    for (int k = 0; k < n; k++) begin
      b = data[8*(n-1-k) +: 8];
      spi_byte(b, r);
    end
    cs_high();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rom_do_ready = v;
  endtask

  task automatic status_read(input logic [7:0] exp, input string tag);
    logic [7:0] r0, r1;
    cs_low();
    spi_byte(8'h08, r0);
    spi_byte(8'h00, r1);
    cs_high();
    checks++;
    if (r0 !== 8'h00) begin
      errors++;
      $display("FAIL %s miso_cmd_slot got=%h exp=00", tag, r0);
    end
    checks++;
    if (r1 !== exp) begin
      errors++;
      $display("FAIL %s status got=%h exp=%h", tag, r1, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (core_config !== {NUM_CFG{CFG_RESET}}) begin
      errors++; $display("FAIL reset core_config got=%h exp=%h", core_config, {NUM_CFG{CFG_RESET}});
    end
    checks++;
    if ({overlay, rom_loading, txt_cursor_we, txt_char_we, rom_do_valid, sspi_miso} !== 6'b0) begin
      errors++; $display("FAIL reset flags got=%b exp=000000",
        {overlay, rom_loading, txt_cursor_we, txt_char_we, rom_do_valid, sspi_miso});
    end
    checks++;
    if ({txt_cursor, txt_char, rom_do} !== 40'h0) begin
      errors++; $display("FAIL reset data got=%h exp=0", {txt_cursor, txt_char, rom_do});
    end
  endtask

  task automatic test_setcfg();
    frame(128'h02_01_78_56_34_12, 6);
    checks++;
    if (core_config[63:32] !== 32'h1234_5678) begin
      errors++; $display("FAIL setcfg cfg1 got=%h exp=12345678", core_config[63:32]);
    end
    checks++;
    if (core_config[31:0] !== CFG_RESET) begin
      errors++; $display("FAIL setcfg cfg0 got=%h exp=%h", core_config[31:0], CFG_RESET);
    end
    frame(128'h02_05_AA_BB_CC_DD, 6);
    checks++;
    if (core_config !== {32'h1234_5678, CFG_RESET}) begin
      errors++; $display("FAIL setcfg idx_oob got=%h exp=%h", core_config, {32'h1234_5678, CFG_RESET});
    end
    frame(128'h02_00_EF_BE_AD_DE, 6);
    checks++;
    if (core_config !== {32'h1234_5678, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL setcfg cfg0_write got=%h exp=%h", core_config, {32'h1234_5678, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_overlay_loading();
    frame(128'h03_01, 2);
    checks++;
    if (overlay !== 1'b1) begin errors++; $display("FAIL overlay_set got=%b exp=1", overlay); end
    frame(128'h03_FE, 2);
    checks++;
    if (overlay !== 1'b0) begin errors++; $display("FAIL overlay_bit0 got=%b exp=0", overlay); end
    frame(128'h06_03, 2);
    checks++;
    if (rom_loading !== 1'b1) begin errors++; $display("FAIL rom_loading got=%b exp=1", rom_loading); end
  endtask

  task automatic test_text();
    exp_cursor_q.push_back(16'h0510);
    frame(128'h04_10_05, 3);
    checks++;
    if (txt_cursor !== 16'h0510) begin errors++; $display("FAIL cursor_value got=%h exp=0510", txt_cursor); end
    exp_char_q.push_back(8'h41);
    exp_char_q.push_back(8'h42);
    frame(128'h05_41_42_00_43, 5);
    checks++;
    if (exp_char_q.size() != 0 || exp_cursor_q.size() != 0) begin
      errors++; $display("FAIL text_pending chars=%0d cursors=%0d exp=0", exp_char_q.size(), exp_cursor_q.size());
    end
  endtask

  task automatic test_romdata();
    set_ready(1'b1);
    exp_rom_q.push_back(16'h2211);
    exp_rom_q.push_back(16'h0033);
    frame(128'h07_03_00_00_11_22_33_44, 8);
    repeat (5) @(posedge clk);
    checks++;
    if (exp_rom_q.size() != 0) begin errors++; $display("FAIL romdata_pending got=%0d exp=0", exp_rom_q.size()); end
    checks++;
    if (rom_do_valid !== 1'b0) begin errors++; $display("FAIL romdata_valid got=%b exp=0", rom_do_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] r;
    set_ready(1'b0);
    cs_low();
    spi_byte(8'h07, r);
    spi_byte(8'h0A, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    for (int k = 1; k <= 10; k++) spi_byte(8'(k), r);
    cs_high();
    checks++;
    if (rom_do_valid !== 1'b1 || rom_do !== 16'h0201) begin
      errors++; $display("FAIL ovf_head valid=%b got=%h exp=0201", rom_do_valid, rom_do);
    end
    status_read(8'h07, "status_ovf");
    status_read(8'h05, "status_ovf_cleared");
    exp_rom_q.push_back(16'h0201);
    exp_rom_q.push_back(16'h0403);
    exp_rom_q.push_back(16'h0605);
    exp_rom_q.push_back(16'h0807);
    set_ready(1'b1);
    repeat (10) @(posedge clk);
    checks++;
    if (exp_rom_q.size() != 0 || rom_do_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain pending=%0d valid=%b exp=0/0", exp_rom_q.size(), rom_do_valid);
    end
    status_read(8'h04, "status_drained");
  endtask

  task automatic test_getconf();
    logic [8*CONF_LEN-1:0] conf_v;
    logic [7:0] r, e;
    conf_v = "Tangcores;-;V,v20240101";
    exp_miso_q.push_back(8'h00);
    for (int k = 0; k < int'(CONF_LEN); k++) exp_miso_q.push_back(conf_v[8*(int'(CONF_LEN)-1-k) +: 8]);
    exp_miso_q.push_back(8'h00);
    exp_miso_q.push_back(8'h00);
    cs_low();
    for (int k = 0; k < int'(CONF_LEN) + 3; k++) begin
      spi_byte((k == 0) ? 8'h01 : 8'hFF, r);
      e = exp_miso_q.pop_front();
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL getconf byte%0d got=%h exp=%h", k, r, e);
      end
    end
    cs_high();
  endtask

  task automatic test_cs_abort();
    logic [7:0] r;
    set_ready(1'b1);
    cs_low();
    spi_byte(8'h07, r);
    spi_byte(8'h02, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h99, r);
    for (int i = 0; i < 4; i++) begin
      sspi_mosi = 1'b1;
      #(HALF);
      sspi_clk = 1'b1;
      #(HALF);
      sspi_clk = 1'b0;
    end
    cs_high();
    checks++;
    if (rom_do_valid !== 1'b0) begin errors++; $display("FAIL abort_push valid=%b exp=0", rom_do_valid); end
    frame(128'h03_01, 2);
    checks++;
    if (overlay !== 1'b1) begin errors++; $display("FAIL abort_next_frame overlay=%b exp=1", overlay); end
    exp_rom_q.push_back(16'h0055);
    frame(128'h07_01_00_00_55, 5);
    repeat (5) @(posedge clk);
    checks++;
    if (exp_rom_q.size() != 0) begin errors++; $display("FAIL abort_single_word pending=%0d exp=0", exp_rom_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    set_ready(1'b0);
    frame(128'h07_01_00_00_66, 5);
    checks++;
    if (rom_do_valid !== 1'b1) begin errors++; $display("FAIL pre_reset valid=%b exp=1", rom_do_valid); end
    cs_low();
    spi_byte(8'h03, r);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    spi_byte(8'h01, r);
    repeat (5) @(posedge clk);
    test_reset();
    cs_high();
    frame(128'h03_01, 2);
    checks++;
    if (overlay !== 1'b1) begin errors++; $display("FAIL post_reset_frame overlay=%b exp=1", overlay); end
    status_read(8'h00, "status_after_reset");
  endtask

  initial begin
    reset        = 1'b1;
    sspi_cs      = 1'b1;
    sspi_clk     = 1'b0;
    sspi_mosi    = 1'b0;
    rom_do_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    test_reset();
    test_setcfg();
    test_overlay_loading();
    test_text();
    test_romdata();
    test_overflow();
    test_getconf();
    test_cs_abort();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
